e_muldiv: RTL
=============

// Module: e_muldiv
// PURPOSE
// - Execute-stage multiply/divide unit with HI/LO registers.
// - Consumes the ID/EX register outputs: operation decoded from the E-stage instruction,
//   forwarded rs/rt values.
// - Drives HI/LO toward the EX/MEM path and a busy flag back to the hazard unit.
// - Hazard unit stalls D on any MD instruction while start|busy.
// PARAMETERS
// - MULT_CYCLES  5   busy cycles after a MULT/MULTU/MADD start (>=1)
// - DIV_CYCLES   10  busy cycles after a DIV/DIVU start (>=1)
// PORTS
// - clk      in   1   rising-edge clock
// - reset    in   1   asynchronous, active-low (0 = reset)
// - start    in   1   E-stage instr is an MD op this cycle; sampled at posedge
// - md_op    in   3   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD
// - a        in   32  forwarded rs value
// - b        in   32  forwarded rt value
// - busy     out  1   multi-cycle operation in flight
// - hi       out  32  HI register
// - lo       out  32  LO register
// BEHAVIOUR
// - Reset (async, reset==0): hi=0, lo=0, busy=0, cnt=0, pending regs=0.
//   Aborts any op in flight; no commit.
// - Counter: cnt width $clog2(max(MULT_CYCLES,DIV_CYCLES)+1); busy = (cnt!=0), combinational.
// - States: IDLE (cnt==0) / RUN (cnt!=0).
// - IDLE, start with mult op: cnt<=MULT_CYCLES, pend_hi/pend_lo<=result.
// - IDLE, start with div op: cnt<=DIV_CYCLES, pend_hi/pend_lo<=result.
// - RUN: cnt decrements each edge. The edge taking cnt 1->0 writes hi/lo<=pend_hi/pend_lo.
// - Latency: start sampled at edge E0. busy is high for exactly N cycles after E0.
//   The new hi/lo are visible the first cycle busy is low.
// - MTHI/MTLO: hi<=a (resp. lo<=a) at the sampling edge; single cycle, busy stays 0.
// - MULT: {hi,lo} = $signed(a)*$signed(b), 64-bit.
// - MULTU: {hi,lo} = a*b, unsigned 64-bit.
// - DIV: lo = signed quotient, truncated toward zero; hi = remainder, sign of dividend.
//   0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
// - DIVU: unsigned quotient/remainder.
// - Divide by zero (b==0): op runs the full DIV_CYCLES; hi/lo left unchanged at commit.
// - start while busy: ignored, no state change; sim-only assertion fires (hazard unit bug).
// - start with md_op NONE: no effect.
// - MTHI/MTLO while busy: ignored plus assertion; stall logic prevents it.
// - reset deassert: normal operation resumes at the next posedge.
// CONFIGURATION
// - Macro MULDIV_MADD_EN.
// - Defined: md_op 7 = MADD, {hi,lo} <= {hi,lo} + $signed(a)*$signed(b) (64-bit, wraps).
//   The sum is formed at the start edge from the current hi/lo; MULT_CYCLES latency.
// - Undefined: md_op 7 is treated as NONE (no busy, hi/lo untouched).
// STRUCTURE
// - Package muldiv_pkg: md_op encoding constants (MD_NONE..MD_MADD) and the md_op_t typedef.
// - Sub-module muldiv_calc: purely combinational.
//   Inputs md_op, a, b, hi, lo; outputs res_hi, res_lo, is_mult, is_div, div_zero.
// - e_muldiv holds cnt, pend regs, hi/lo and the sequencing logic.
// TESTING
// - MULT a=0xFFFFFFFE(-2), b=3 -> busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
// - MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
// - DIV a=-7, b=2 -> busy 10 cycles; lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//   Then DIVU 7/0 -> hi/lo unchanged.
// - MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on the next cycle.
//   -> hi/lo updated one edge each, busy never high.
// - DIV started, reset pulled low at busy cycle 4.
//   -> hi=lo=0, busy=0 immediately; no later commit.
// - With MULDIV_MADD_EN: hi=0, lo=0xFFFFFFFF, MADD a=1, b=1 -> hi=1, lo=0.
//   Without the macro: no busy, hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package muldiv_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_NONE  = 3'd0;
  localparam md_op_t MD_MULT  = 3'd1;
  localparam md_op_t MD_MULTU = 3'd2;
  localparam md_op_t MD_DIV   = 3'd3;
  localparam md_op_t MD_DIVU  = 3'd4;
  localparam md_op_t MD_MTHI  = 3'd5;
  localparam md_op_t MD_MTLO  = 3'd6;
  localparam md_op_t MD_MADD  = 3'd7;

  // IDLE while the countdown is zero, RUN while an op is in flight.
  typedef enum logic {StIdle, StRun} md_state_e;

endpackage

// File: rtl/muldiv_calc.sv
// Combinational result generator for the multiply/divide unit.
// MADD (md_op 7) is only decoded when MULDIV_MADD_EN is defined.
module muldiv_calc
  import muldiv_pkg::*;
(
  input  md_op_t      md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        is_mult,
  output logic        is_div,
  output logic        div_zero
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u, divisor_s, divisor_u;

  // Products, magnitude-based signed divide (handles 0x80000000 / -1 without overflow).
  always_comb begin
    prod_s    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u    = {32'd0, a} * {32'd0, b};
    a_mag     = a[31] ? (~a + 32'd1) : a;
    b_mag     = b[31] ? (~b + 32'd1) : b;
    // Substitute 1 for a zero divisor; the result is discarded in that case anyway.
    divisor_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
    divisor_u = (b == 32'd0) ? 32'd1 : b;
    q_mag     = a_mag / divisor_s;
    r_mag     = a_mag % divisor_s;
    q_s       = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s       = a[31] ? (~r_mag + 32'd1) : r_mag;
    q_u       = a / divisor_u;
    r_u       = a % divisor_u;
  end

  // Operation select; a zero-divisor divide returns the current HI/LO unchanged.
  always_comb begin
    res_hi   = hi;
    res_lo   = lo;
    is_mult  = 1'b0;
    is_div   = 1'b0;
    div_zero = 1'b0;
    case (md_op)
      MD_MULT: begin
        is_mult          = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      MD_MULTU: begin
        is_mult          = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      MD_DIV: begin
        is_div   = 1'b1;
        div_zero = (b == 32'd0);
        if (!div_zero) begin
          res_hi = r_s;
          res_lo = q_s;
        end
      end
      MD_DIVU: begin
        is_div   = 1'b1;
        div_zero = (b == 32'd0);
        if (!div_zero) begin
          res_hi = r_u;
          res_lo = q_u;
        end
      end
`ifdef MULDIV_MADD_EN
      MD_MADD: begin
        is_mult          = 1'b1;
        {res_hi, res_lo} = {hi, lo} + prod_s;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/e_muldiv.sv
// Execute-stage multiply/divide unit with HI/LO registers and busy countdown.
// Optional MADD support is enabled by defining MULDIV_MADD_EN.
module e_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     res_hi, res_lo;
  logic            is_mult, is_div, div_zero;
  md_state_e       state;

  muldiv_calc u_calc (
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .hi       (hi_q),
    .lo       (lo_q),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .is_mult  (is_mult),
    .is_div   (is_div),
    .div_zero (div_zero)
  );

  assign state = (cnt_q != '0) ? StRun : StIdle;
  assign busy  = (cnt_q != '0);
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Launch, count down and commit; starts arriving while running are dropped.
  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state)
      StIdle: begin
        if (start) begin
          if (is_mult || is_div) begin
            cnt_d     = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
          end else if (md_op == MD_MTHI) begin
            hi_d = a;
          end else if (md_op == MD_MTLO) begin
            lo_d = a;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
      default: ;
    endcase
  end

  // State registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

`ifndef SYNTHESIS
  // The hazard unit must stall any MD op while busy; this catching means a stall bug.
  a_no_start_while_busy : assert property (@(posedge clk) disable iff (!reset)
    !(start && busy && (md_op != MD_NONE)));
  // div_zero only ever accompanies a divide decode.
  a_div_zero_is_div : assert property (@(posedge clk) disable iff (!reset)
    !(div_zero && !is_div));
`endif

endmodule
